// File: rtl/prog_mem_pp_pkg.sv
// Shared types and constants for the flash parallel-programming controller:
// command codes, XA strobe decode and the programming engine states.
package prog_mem_pp_pkg;

  localparam logic [7:0]  CMD_CHIP_ERASE  = 8'h80;
  localparam logic [7:0]  CMD_WRITE_FLASH = 8'h10;
  localparam logic [7:0]  CMD_READ_FLASH  = 8'h02;
  localparam logic [15:0] ERASED_WORD     = 16'hFFFF;

  typedef enum logic [1:0] {
    XA_ADDR = 2'b00,
    XA_DATA = 2'b01,
    XA_CMD  = 2'b10,
    XA_NOP  = 2'b11
  } xa_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ERASE_PG   = 3'd1,
    WRITE_PG   = 3'd2,
    CHIP_ERASE = 3'd3,
    WAIT       = 3'd4,
    READ       = 3'd5
  } eng_state_e;

endpackage

// File: rtl/prog_mem_pp_ctrl_if.sv
// Word-wide port between the programming controller and the flash array macro.
// Handshake: a synchronous array; mem_en&mem_we writes at the edge, mem_en&!mem_we
// returns mem_rdata the cycle after. No back-pressure: the array accepts every cycle.
interface prog_mem_pp_ctrl_if #(
  parameter int WA_W = 14
);
  logic            mem_en;
  logic            mem_we;
  logic [WA_W-1:0] mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;

  modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/prog_mem_page_buf.sv
// Page buffer: PAGE_WORDS x 16 registers with indexed write, combinational
// indexed read, and a synchronous fill to the erased value.
module prog_mem_page_buf
  import prog_mem_pp_pkg::*;
#(
  parameter  int PAGE_WORDS = 64,
  localparam int IW         = $clog2(PAGE_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [15:0]   wdata,
  input  logic [IW-1:0] ridx,
  output logic [15:0]   rdata
);
  logic [15:0] words [PAGE_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n || fill) begin
      for (int i = 0; i < PAGE_WORDS; i++) words[i] <= ERASED_WORD;
    end else if (we) begin
      words[widx] <= wdata;
    end
  end

  assign rdata = words[ridx];
endmodule

// File: rtl/prog_mem_pp_ctrl.sv
// Parallel-programming controller: decodes the XA/BS1/XTAL1/WR/OE strobes, runs
// page erase+write, chip erase and byte read, and shares the array port with fetch.
module prog_mem_pp_ctrl
  import prog_mem_pp_pkg::*;
#(
  parameter int PAGES           = 256,
  parameter int PAGE_WORDS      = 64,
  parameter int NRWW_FIRST_PAGE = 224,
  parameter int PROG_WAIT       = 32,
  parameter int WA_W            = $clog2(PAGES * PAGE_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pp_xtal1,
  input  logic [1:0]         pp_xa,
  input  logic               pp_bs1,
  input  logic               pp_wr_n,
  input  logic               pp_oe_n,
  input  logic [7:0]         pp_din,
  output logic [7:0]         pp_dout,
  output logic               pp_dout_en,
  output logic               rdy,
  input  logic [WA_W-1:0]    pc,
  input  logic               pc_rd,
  output logic [15:0]        instr,
  output logic               instr_valid,
  output logic               rww_busy,
  prog_mem_pp_ctrl_if.master mem,
  output eng_state_e         dbg_state
);
  localparam int ARRAY_WORDS = PAGES * PAGE_WORDS;
  localparam int IW          = $clog2(PAGE_WORDS);
  localparam int PG_W        = WA_W - IW;
  localparam int CNT_W       = (WA_W > $clog2(PROG_WAIT) + 1) ? WA_W : $clog2(PROG_WAIT) + 1;

  eng_state_e       state, state_n;
  logic             xtal1_q, wr_n_q, xtal_rise, wr_fall;
  logic [7:0]       cmd, dlo;
  logic [15:0]      addr;
  logic [WA_W-1:0]  word_addr;
  logic [PG_W-1:0]  page_q;
  logic             op_chip, busy, page_rww, pc_rww, stall;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc, wait_done, eng_start;
  logic             eng_we, eng_rd, rd_issue, rd_pend, fetch_go, fetch_pend;
  logic [WA_W-1:0]  eng_addr;
  logic [15:0]      eng_wdata, buf_rdata, rd_data;
  logic             load_en, buf_we;

  assign xtal_rise = pp_xtal1 & ~xtal1_q;
  assign wr_fall   = ~pp_wr_n & wr_n_q;
  assign word_addr = WA_W'(32'(addr) % ARRAY_WORDS);
  assign busy      = state inside {ERASE_PG, WRITE_PG, CHIP_ERASE, WAIT};
  assign page_rww  = int'(page_q) < NRWW_FIRST_PAGE;
  assign pc_rww    = int'(pc[WA_W-1:IW]) < NRWW_FIRST_PAGE;
  assign rww_busy  = busy & (op_chip | page_rww);
  // An RWW-page operation blocks only RWW fetches; NRWW or chip operations block all.
  assign stall     = busy & (op_chip | ~page_rww | pc_rww);
  assign fetch_go  = pc_rd & ~stall & ~fetch_pend & ~instr_valid;
  assign rd_issue  = eng_rd & ~fetch_go;
  assign rdy       = ~busy;
  assign load_en   = xtal_rise & rdy & ~eng_start;
  assign buf_we    = load_en & (xa_e'(pp_xa) == XA_DATA) & pp_bs1;
  assign pp_dout_en = ~pp_oe_n & (cmd == CMD_READ_FLASH);
  assign pp_dout    = pp_bs1 ? rd_data[15:8] : rd_data[7:0];
  assign dbg_state  = state;

  prog_mem_page_buf #(.PAGE_WORDS(PAGE_WORDS)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .fill  (wait_done),
    .we    (buf_we),
    .widx  (addr[IW-1:0]),
    .wdata ({pp_din, dlo}),
    .ridx  (cnt[IW-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wait_done = 1'b0;
    eng_start = 1'b0;
    eng_we    = 1'b0;
    eng_rd    = 1'b0;
    eng_wdata = ERASED_WORD;
    eng_addr  = {page_q, cnt[IW-1:0]};
    unique case (state)
      IDLE: begin
        eng_addr = word_addr;
        if (wr_fall && (cmd == CMD_WRITE_FLASH || cmd == CMD_CHIP_ERASE)) begin
          eng_start = 1'b1;
          cnt_clr   = 1'b1;
          state_n   = (cmd == CMD_WRITE_FLASH) ? ERASE_PG : CHIP_ERASE;
        end else if (pp_dout_en) begin
          eng_rd  = 1'b1;
          state_n = READ;
        end
      end
      READ: begin
        eng_addr = word_addr;
        if (pp_dout_en) eng_rd  = 1'b1;
        else            state_n = IDLE;
      end
      ERASE_PG, WRITE_PG: begin
        eng_we = 1'b1;
        if (state == WRITE_PG) eng_wdata = buf_rdata;
        if (!fetch_go) begin
          if (cnt[IW-1:0] == IW'(PAGE_WORDS - 1)) begin
            cnt_clr = 1'b1;
            state_n = (state == ERASE_PG) ? WRITE_PG : WAIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CHIP_ERASE: begin
        eng_we   = 1'b1;
        eng_addr = cnt[WA_W-1:0];
        if (!fetch_go) begin
          if (cnt == CNT_W'(ARRAY_WORDS - 1)) begin
            cnt_clr = 1'b1;
            state_n = WAIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(PROG_WAIT - 1)) begin
          wait_done = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fetch wins the port; the engine only uses cycles fetch leaves free.
  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc;
    mem.mem_wdata = eng_wdata;
    if (fetch_go) begin
      mem.mem_en = rst_n;
    end else if (eng_we || eng_rd) begin
      mem.mem_en   = rst_n;
      mem.mem_we   = eng_we;
      mem.mem_addr = eng_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xtal1_q     <= 1'b1;
      wr_n_q      <= 1'b0;
      cmd         <= 8'h00;
      addr        <= 16'h0000;
      dlo         <= 8'h00;
      cnt         <= '0;
      page_q      <= '0;
      op_chip     <= 1'b0;
      fetch_pend  <= 1'b0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      rd_pend     <= 1'b0;
      rd_data     <= 16'h0000;
    end else begin
      xtal1_q     <= pp_xtal1;
      wr_n_q      <= pp_wr_n;
      fetch_pend  <= fetch_go;
      instr_valid <= fetch_pend;
      rd_pend     <= rd_issue;
      if (fetch_pend) instr   <= mem.mem_rdata;
      if (rd_pend)    rd_data <= mem.mem_rdata;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (eng_start) begin
        page_q  <= word_addr[WA_W-1:IW];
        op_chip <= (cmd == CMD_CHIP_ERASE);
      end
      if (load_en) begin
        case (xa_e'(pp_xa))
          XA_CMD:  cmd <= pp_din;
          XA_ADDR: if (pp_bs1) addr[15:8] <= pp_din; else addr[7:0] <= pp_din;
          XA_DATA: if (!pp_bs1) dlo <= pp_din;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_mem_pp_ctrl.sv
// Directed bench for prog_mem_pp_ctrl with a behavioural flash array model and
// immediate-assertion checks against hand-computed values.
module tb_prog_mem_pp_ctrl;
  import prog_mem_pp_pkg::*;

  localparam int PAGES = 256, PAGE_WORDS = 64, NRWW_FIRST_PAGE = 224, PROG_WAIT = 32;
  localparam int WA_W = 14;
  localparam int ARRAY_WORDS = PAGES * PAGE_WORDS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pp_xtal1, pp_bs1, pp_wr_n, pp_oe_n, pc_rd;
  logic [1:0] pp_xa;
  logic [7:0] pp_din, pp_dout;
  logic pp_dout_en, rdy, instr_valid, rww_busy;
  logic [WA_W-1:0] pc;
  logic [15:0] instr;
  eng_state_e dbg_state;

  prog_mem_pp_ctrl_if #(.WA_W(WA_W)) mem_if ();

  prog_mem_pp_ctrl #(
    .PAGES(PAGES), .PAGE_WORDS(PAGE_WORDS), .NRWW_FIRST_PAGE(NRWW_FIRST_PAGE),
    .PROG_WAIT(PROG_WAIT), .WA_W(WA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pp_xtal1(pp_xtal1), .pp_xa(pp_xa), .pp_bs1(pp_bs1),
    .pp_wr_n(pp_wr_n), .pp_oe_n(pp_oe_n), .pp_din(pp_din), .pp_dout(pp_dout),
    .pp_dout_en(pp_dout_en), .rdy(rdy), .pc(pc), .pc_rd(pc_rd), .instr(instr),
    .instr_valid(instr_valid), .rww_busy(rww_busy), .mem(mem_if.master),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // flash array model, preloaded with a recognisable pattern
  function automatic logic [15:0] init_word(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  logic [15:0] arr [ARRAY_WORDS];
  bit arr_ready = 1'b0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (!arr_ready) begin
      for (int i = 0; i < ARRAY_WORDS; i++) arr[i] <= init_word(i);
      arr_ready <= 1'b1;
    end else if (mem_if.mem_en) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_if.mem_we) arr[mem_if.mem_addr] <= mem_if.mem_wdata;
      else               mem_if.mem_rdata <= arr[mem_if.mem_addr];
    end
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xload(input logic [1:0] xa, input logic bs1, input logic [7:0] din);
    pp_xa = xa; pp_bs1 = bs1; pp_din = din; pp_xtal1 = 1'b1;
    tick();
    pp_xtal1 = 1'b0;
    tick();
  endtask

  task automatic wr_pulse();
    pp_wr_n = 1'b0;
    tick();
    pp_wr_n = 1'b1;
    tick();
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int n = 0;
    while (!rdy && n < budget) begin tick(); n++; end
    check(tag, 32'(rdy), 32'd1);
  endtask

  task automatic count_bad_page(input int page, input int hot_word, input logic [15:0] hot_val,
                                output int bad);
    bad = 0;
    for (int i = 0; i < PAGE_WORDS; i++)
      if (arr[page * PAGE_WORDS + i] !== ((i == hot_word) ? hot_val : 16'hFFFF)) bad++;
  endtask

  int busy, bad, lat, rww_seen, n;

  initial begin
    pp_xtal1 = 1'b0; pp_xa = 2'b11; pp_bs1 = 1'b0; pp_wr_n = 1'b1; pp_oe_n = 1'b1;
    pp_din = 8'h00; pc = '0; pc_rd = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_rww_busy", 32'(rww_busy), 32'd0);
    check("rst_dout", 32'(pp_dout), 32'h00);
    check("rst_dout_en", 32'(pp_dout_en), 32'd0);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_mem_en", 32'(mem_if.mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // page 1 write: word 1 = F69F, busy for erase + write + settle
    xload(XA_CMD, 1'b0, 8'h10);
    xload(XA_ADDR, 1'b0, 8'h41);
    xload(XA_ADDR, 1'b1, 8'h00);
    xload(XA_DATA, 1'b0, 8'h9F);
    xload(XA_DATA, 1'b1, 8'hF6);
    pp_wr_n = 1'b0;
    tick();
    check("wr_rdy_drop", 32'(rdy), 32'd0);
    check("wr_rww_busy", 32'(rww_busy), 32'd1);
    pp_wr_n = 1'b1;
    busy = 1;
    while (busy < 400) begin
      tick();
      if (rdy) break;
      busy++;
    end
    check("pg1_busy_cycles", 32'(busy), 32'(2 * PAGE_WORDS + PROG_WAIT));
    check("pg1_word1", 32'(arr[16'h0041]), 32'hF69F);
    count_bad_page(1, 1, 16'hF69F, bad);
    check("pg1_other_words", 32'(bad), 32'd0);
    check("pg0_last_untouched", 32'(arr[16'h003F]), 32'(init_word(16'h003F)));
    check("pg2_first_untouched", 32'(arr[16'h0080]), 32'(init_word(16'h0080)));

    // buffer was refilled: a page write with no data loads gives an erased page
    xload(XA_ADDR, 1'b0, 8'h80);
    wr_pulse();
    wait_rdy("pg2_done", 400);
    count_bad_page(2, -1, 16'hFFFF, bad);
    check("pg2_buffer_cleared", 32'(bad), 32'd0);

    // fetch during an RWW page write
    xload(XA_ADDR, 1'b0, 8'h41);
    xload(XA_DATA, 1'b0, 8'h9F);
    xload(XA_DATA, 1'b1, 8'hF6);
    wr_pulse();
    check("rww_wr_busy", 32'(rww_busy), 32'd1);
    exp_q.push_back(init_word(16'h3841));
    pc = 14'h3841; pc_rd = 1'b1; lat = 0;
    while (lat < 10) begin
      tick(); lat++;
      if (instr_valid) break;
    end
    pc_rd = 1'b0;
    check("nrww_fetch_valid", 32'(instr_valid), 32'd1);
    check("nrww_fetch_lat_le2", 32'(lat <= 2), 32'd1);
    check("nrww_fetch_instr", 32'(instr), 32'(exp_q.pop_front()));
    tick();
    exp_q.push_back(16'hF69F);
    pc = 14'h0041; pc_rd = 1'b1; n = 0;
    while (n < 600) begin
      tick(); n++;
      if (instr_valid) break;
    end
    pc_rd = 1'b0;
    check("rww_fetch_valid", 32'(instr_valid), 32'd1);
    check("rww_fetch_after_rdy", 32'(rdy), 32'd1);
    check("rww_fetch_instr", 32'(instr), 32'(exp_q.pop_front()));
    tick();

    // NRWW page 0xE1 write: every fetch stalls, rww_busy stays low
    xload(XA_ADDR, 1'b0, 8'h42);
    xload(XA_ADDR, 1'b1, 8'h38);
    xload(XA_DATA, 1'b0, 8'hCD);
    xload(XA_DATA, 1'b1, 8'hAB);
    wr_pulse();
    check("nrww_rdy_low", 32'(rdy), 32'd0);
    exp_q.push_back(init_word(0));
    pc = 14'h0000; pc_rd = 1'b1; n = 0; rww_seen = 0;
    while (n < 600) begin
      tick(); n++;
      if (rww_busy) rww_seen++;
      if (instr_valid) break;
    end
    pc_rd = 1'b0;
    check("nrww_rww_busy_low", 32'(rww_seen), 32'd0);
    check("nrww_fetch_valid", 32'(instr_valid), 32'd1);
    check("nrww_fetch_after_rdy", 32'(rdy), 32'd1);
    check("nrww_stalled_instr", 32'(instr), 32'(exp_q.pop_front()));
    count_bad_page(16'hE1, 2, 16'hABCD, bad);
    check("pgE1_contents", 32'(bad), 32'd0);
    check("pgE1_word2", 32'(arr[16'h3842]), 32'hABCD);
    tick();

    // byte read of 0x3842
    xload(XA_CMD, 1'b0, 8'h02);
    pp_bs1 = 1'b0; pp_oe_n = 1'b0;
    tick();
    tick();
    check("read_dout_en", 32'(pp_dout_en), 32'd1);
    check("read_lo_byte", 32'(pp_dout), 32'hCD);
    pp_bs1 = 1'b1;
    tick();
    check("read_hi_byte", 32'(pp_dout), 32'hAB);
    pp_oe_n = 1'b1;
    tick();
    check("read_dout_en_off", 32'(pp_dout_en), 32'd0);

    // chip erase; loads while busy must be ignored
    xload(XA_CMD, 1'b0, 8'h80);
    wr_pulse();
    check("chip_rww_busy", 32'(rww_busy), 32'd1);
    xload(XA_CMD, 1'b0, 8'h02);
    xload(XA_ADDR, 1'b0, 8'h00);
    wait_rdy("chip_done", 20000);
    tick();
    check("chip_w0", 32'(arr[0]), 32'hFFFF);
    check("chip_w3842", 32'(arr[16'h3842]), 32'hFFFF);
    check("chip_wlast", 32'(arr[ARRAY_WORDS - 1]), 32'hFFFF);
    bad = 0;
    for (int i = 0; i < ARRAY_WORDS; i++) if (arr[i] !== 16'hFFFF) bad++;
    check("chip_all_erased", 32'(bad), 32'd0);
    exp_q.push_back(16'hFFFF);
    pc = 14'h3FFF; pc_rd = 1'b1; n = 0;
    while (n < 10) begin
      tick(); n++;
      if (instr_valid) break;
    end
    pc_rd = 1'b0;
    check("chip_fetch_instr", 32'(instr), 32'(exp_q.pop_front()));
    tick();
    pp_oe_n = 1'b0;
    tick();
    check("busy_cmd_load_ignored", 32'(pp_dout_en), 32'd0);
    pp_oe_n = 1'b1;
    tick();

    // reset mid-erase abandons the operation and clears the buffer
    xload(XA_CMD, 1'b0, 8'h10);
    xload(XA_ADDR, 1'b0, 8'hC0);
    xload(XA_ADDR, 1'b1, 8'h00);
    xload(XA_DATA, 1'b0, 8'h34);
    xload(XA_DATA, 1'b1, 8'h12);
    wr_pulse();
    repeat (5) tick();
    check("mid_erase_state", 32'(dbg_state), 32'(ERASE_PG));
    rst_n = 1'b0;
    tick();
    check("rst_mid_rdy", 32'(rdy), 32'd1);
    check("rst_mid_mem_en", 32'(mem_if.mem_en), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    xload(XA_CMD, 1'b0, 8'h10);
    xload(XA_ADDR, 1'b0, 8'hC0);
    wr_pulse();
    wait_rdy("pg3_done", 400);
    count_bad_page(3, -1, 16'hFFFF, bad);
    check("rst_buffer_cleared", 32'(bad), 32'd0);

    // undefined command: WR_n pulse touches nothing
    xload(XA_CMD, 1'b0, 8'h55);
    n = acc_cnt;
    wr_pulse();
    repeat (10) tick();
    check("undef_cmd_no_access", 32'(acc_cnt - n), 32'd0);
    check("undef_cmd_rdy", 32'(rdy), 32'd1);

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/prog_mem_pp_ctrl.md
Name: prog_mem_pp_ctrl

Overview:
- Parametrised parallel-programming controller for the flash program memory: decodes XA/BS1/XTAL1/WR/OE programming strobes, owns a page buffer, and sequences page erase+write, chip erase and byte read through a word-wide port to an external array.
- Arbitrates that port against CPU instruction fetch.
- Enforces RWW/NRWW fetch stalls while a section is busy.
- Sits between the pin interface/fetch unit and the flash array macro.

Parameters:
- PAGES, 256, number of flash pages.
- PAGE_WORDS, 64, 16-bit words per page (power of 2).
- NRWW_FIRST_PAGE, 224, first page of the NRWW section; pages below it are RWW.
- PROG_WAIT, 32, clk cycles of post-write settling before RDY returns high (≥1).
- WA_W, $clog2(PAGES*PAGE_WORDS), word-address width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pp_xtal1  in  1  load strobe; action on sampled rising edge.
- pp_xa  in  2  00 address, 01 data, 10 command, 11 no-op.
- pp_bs1  in  1  byte select: 0 low byte, 1 high byte.
- pp_wr_n  in  1  start strobe; action on sampled falling edge.
- pp_oe_n  in  1  read enable, active low.
- pp_din  in  8  programming data bus in.
- pp_dout  out  8  read data.
- pp_dout_en  out  1  pp_dout drive enable.
- rdy  out  1  1 = idle, 0 = busy.
- pc  in  WA_W  fetch word address.
- pc_rd  in  1  fetch request, held until instr_valid.
- instr  out  16  fetched word.
- instr_valid  out  1  one-cycle fetch-complete pulse.
- rww_busy  out  1  RWW page being altered.
- mem_en  out  1  array access.
- mem_we  out  1  array write.
- mem_addr  out  WA_W  array word address.
- mem_wdata  out  16  array write data.
- mem_rdata  in  16  array read data, valid the cycle after mem_en & !mem_we.

Behaviour:
- All inputs are synchronous to clk. Edge detection uses registered previous values of pp_xtal1 and pp_wr_n.
- Reset values: cmd=0x00, addr=0, data latches=0x00, page buffer all 16'hFFFF, state IDLE, rdy=1, rww_busy=0, pp_dout=0, pp_dout_en=0, instr=0, instr_valid=0, mem_en=0, mem_we=0.
- XTAL1 rise with XA=10: cmd<=pp_din. Codes: 0x80 chip erase, 0x10 write flash, 0x02 read flash. Any other code means no operation.
- XTAL1 rise with XA=00: BS1 selects addr[7:0] or addr[15:8].
- XTAL1 rise with XA=01:
  - BS1=0: dlo<=pp_din.
  - BS1=1: buf[addr mod PAGE_WORDS]<={pp_din,dlo}.
- XTAL1 rise with XA=11: ignored.
- While rdy=0, all XTAL1 loads are ignored.
- WR_n fall in IDLE:
  - cmd=0x10 → ERASE_PG at page P=addr[WA_W-1:0]/PAGE_WORDS.
  - cmd=0x80 → CHIP_ERASE.
  - Otherwise ignored.
  - rdy drops the cycle after the edge.
- ERASE_PG: writes 16'hFFFF to all PAGE_WORDS words of P, one write per granted cycle, then → WRITE_PG.
- WRITE_PG: writes buf[0..PAGE_WORDS-1] to P, then → WAIT.
- CHIP_ERASE: writes 16'hFFFF to all PAGES*PAGE_WORDS words, then → WAIT.
- WAIT: counts PROG_WAIT cycles. On completion the buffer is reset to all 16'hFFFF, state returns to IDLE, and rdy=1 in the same cycle.
- READ (cmd=0x02, pp_oe_n=0, rdy=1): the engine reads word addr.
  - pp_dout = BS1 ? rdata[15:8] : rdata[7:0], valid 2 cycles after oe_n falls.
  - The byte choice follows BS1 live while oe_n stays low.
  - pp_dout_en = !pp_oe_n & (cmd==0x02).
- rww_busy=1 during ERASE_PG, WRITE_PG and WAIT when P<NRWW_FIRST_PAGE, and for the whole of CHIP_ERASE.
- Arbitration: fetch has priority on the mem port unless stalled.
  - Fetch is stalled when pc targets RWW and rww_busy=1, or when an NRWW page or chip erase is in progress.
  - A stalled fetch holds pc_rd; instr_valid stays 0 until the stall clears.
  - An unstalled fetch issues a read; instr<=mem_rdata with instr_valid=1 one cycle later.
  - The engine advances only on cycles not granted to fetch. Erase and write counters hold when not granted.
- Address wrap: a word address ≥ PAGES*PAGE_WORDS wraps modulo the array size. Buffer index uses the low log2(PAGE_WORDS) bits.
- Simultaneous WR_n fall and XTAL1 rise: the command start wins and the load is dropped.
- rst_n low mid-operation: immediate return to reset values next edge; a partial array write is abandoned.

Decomposition:
- Package prog_mem_pp_pkg:
  - command code constants CMD_CHIP_ERASE, CMD_WRITE_FLASH, CMD_READ_FLASH.
  - XA enum (XA_ADDR, XA_DATA, XA_CMD, XA_NOP).
  - engine state enum (IDLE, ERASE_PG, WRITE_PG, CHIP_ERASE, WAIT, READ).
- One sub-module: prog_mem_page_buf, a PAGE_WORDS×16 register buffer with indexed write, indexed read and synchronous fill-to-FFFF.

Test Plan:
- Load cmd 0x10, addr 0x0041, data 0x9F then 0xF6, WR_n pulse → page 1 word 1 = 16'hF69F, all other words in page 1 = FFFF. rdy low through ERASE, WRITE and PROG_WAIT, then high. Buffer reads back all FFFF.
- During a page-1 (RWW) write, pc_rd at 0x3841 (NRWW) → instr_valid within 2 cycles. pc_rd at 0x0041 → stalled until rdy=1, then instr=16'hF69F.
- Write page 0xE1 (NRWW) with word 2 = 16'hABCD → any fetch is stalled until completion and rww_busy stays 0. Read cmd 0x02 at addr 0x3842 with OE_n low: BS1=0 gives 0xCD, BS1=1 gives 0xAB.
- Chip erase 0x80 → every sampled word = FFFF. XTAL1 loads during busy are ignored: cmd is unchanged afterwards.
- Assert rst_n low mid-ERASE_PG → next cycle rdy=1, mem_en=0, buffer FFFF. An undefined cmd 0x55 followed by a WR_n pulse → no array access.
